// File: rtl/prbs31_checker_if.sv
// Receive-side bundle of the PRBS31 checker: serial data in, lock/error status out.
// The driver (link receiver or bench) uses master; the checker uses slave.
interface prbs31_checker_if #(
    parameter int ERR_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      bit_cnt;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 (x^31 + x^28 + 1) checker with lock detection,
// windowed loss-of-lock and saturating error/bit counters.
module prbs31_checker #(
    parameter int LOCK_THRESH = 64,
    parameter int LOSS_THRESH = 8,
    parameter int WIN         = 256,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prbs31_checker_if.slave   bus
);
    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int WCNT_W = $clog2(WIN);
    localparam int EWIN_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEED,
        CHECK,
        LOCKED
    } state_e;

    state_e            state_q;
    logic [30:0]       h_q;
    logic [4:0]        seed_cnt_q;
    logic [RUN_W-1:0]  run_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [EWIN_W-1:0] err_win_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [31:0]       bit_cnt_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic              expected;
    logic              match;
    logic [30:0]       h_shift_din;
    logic [ERR_W-1:0]  err_base;
    logic [ERR_W-1:0]  err_inc;
    logic [31:0]       bit_base;
    logic [31:0]       bit_inc;

    // Counter clear is applied before any increment on the same edge.
    always_comb begin
        expected    = h_q[27] ^ h_q[30];
        match       = (bus.din == expected);
        h_shift_din = {h_q[29:0], bus.din};
        err_base    = bus.clr_cnt ? '0 : err_cnt_q;
        bit_base    = bus.clr_cnt ? '0 : bit_cnt_q;
        err_inc     = (&err_base) ? err_base : err_base + ERR_W'(1);
        bit_inc     = (&bit_base) ? bit_base : bit_base + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEED;
            h_q         <= '0;
            seed_cnt_q  <= '0;
            run_q       <= '0;
            wcnt_q      <= '0;
            err_win_q   <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.clr_cnt) begin
                err_cnt_q <= '0;
                bit_cnt_q <= '0;
            end
            if (bus.din_valid) begin
                unique case (state_q)
                    SEED: begin
                        h_q <= h_shift_din;
                        if (seed_cnt_q == 5'd30) begin
                            seed_cnt_q <= '0;
                            // An all-zero seed would predict zeros forever; refill instead.
                            if (h_shift_din != '0) begin
                                state_q <= CHECK;
                                run_q   <= '0;
                            end
                        end else begin
                            seed_cnt_q <= seed_cnt_q + 5'd1;
                        end
                    end
                    CHECK: begin
                        h_q <= h_shift_din;
                        if (!match) begin
                            run_q <= '0;
                        end else if (run_q == RUN_W'(LOCK_THRESH - 1)) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            run_q     <= '0;
                            wcnt_q    <= '0;
                            err_win_q <= '0;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Feed back the prediction so a line error cannot corrupt the taps.
                        h_q       <= {h_q[29:0], expected};
                        bit_cnt_q <= bit_inc;
                        wcnt_q    <= wcnt_q + WCNT_W'(1);
                        if (!match) begin
                            err_pulse_q <= 1'b1;
                            err_cnt_q   <= err_inc;
                        end
                        if (!match && (err_win_q == EWIN_W'(LOSS_THRESH - 1))) begin
                            state_q    <= SEED;
                            locked_q   <= 1'b0;
                            run_q      <= '0;
                            seed_cnt_q <= '0;
                        end else if (&wcnt_q) begin
                            err_win_q <= '0;
                        end else if (!match) begin
                            err_win_q <= err_win_q + EWIN_W'(1);
                        end
                    end
                    default: state_q <= SEED;
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.bit_cnt   = bit_cnt_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: phase table, hand-written corner sequences,
// and randomized traffic compared against a queue-based behavioural model.
module tb_prbs31_checker;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = 15;
    localparam int M_SEED  = 0;
    localparam int M_CHECK = 1;
    localparam int M_LOCK  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    prbs31_checker_if #(.ERR_W(ERR_W)) bus ();

    prbs31_checker #(
        .LOCK_THRESH(64),
        .LOSS_THRESH(8),
        .WIN        (256),
        .ERR_W      (ERR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [30:0] gen;
    int          pulses;
    int          pulse_on_invalid;
    int          locked_seen;
    bit          model_on;

    // Behavioural model: history of the last 31 reference bits, newest at the back.
    int          m_mode;
    bit          m_hist[$];
    int          m_seed_n;
    int          m_run;
    int          m_wbits;
    int          m_werr;
    int          m_err;
    longint      m_bits;
    bit          m_pulse;

    typedef struct {
        string name;
        int    nbits;
        int    ninv;
        bit    exp_locked;
        int    exp_err;
        int    exp_bits;
        int    exp_pulses;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit gen_next();
        bit o;
        o   = gen[30];
        gen = {gen[29:0], gen[27] ^ gen[30]};
        return o;
    endfunction

    task automatic model_reset();
        m_mode   = M_SEED;
        m_hist.delete();
        m_seed_n = 0;
        m_run    = 0;
        m_wbits  = 0;
        m_werr   = 0;
        m_err    = 0;
        m_bits   = 0;
        m_pulse  = 0;
    endtask

    task automatic hist_push(input bit b);
        m_hist.push_back(b);
        if (m_hist.size() > 31) void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit d, input bit v, input bit c);
        bit e;
        bit any_one;
        int n;
        m_pulse = 0;
        if (c) begin
            m_err  = 0;
            m_bits = 0;
        end
        if (!v) return;
        n = m_hist.size();
        e = (n == 31) ? (m_hist[n-28] ^ m_hist[n-31]) : 1'b0;
        case (m_mode)
            M_SEED: begin
                hist_push(d);
                m_seed_n++;
                if (m_seed_n == 31) begin
                    m_seed_n = 0;
                    any_one  = 0;
                    foreach (m_hist[k]) any_one |= m_hist[k];
                    if (any_one) begin
                        m_mode = M_CHECK;
                        m_run  = 0;
                    end
                end
            end
            M_CHECK: begin
                hist_push(d);
                m_run = (d == e) ? m_run + 1 : 0;
                if (m_run == 64) begin
                    m_mode  = M_LOCK;
                    m_wbits = 0;
                    m_werr  = 0;
                end
            end
            default: begin
                hist_push(e);
                if (m_bits < 64'd4294967295) m_bits++;
                if (d != e) begin
                    m_pulse = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_werr++;
                end
                m_wbits++;
                if (m_werr == 8) begin
                    m_mode   = M_SEED;
                    m_seed_n = 0;
                    m_run    = 0;
                end else if (m_wbits == 256) begin
                    m_wbits = 0;
                    m_werr  = 0;
                end
            end
        endcase
    endtask

    // Starts and ends on a falling edge; outputs are sampled there.
    task automatic cycle(input bit d, input bit v, input bit c);
        bus.din       = d;
        bus.din_valid = v;
        bus.clr_cnt   = c;
        @(posedge clk);
        model_step(d, v, c);
        @(negedge clk);
        if (bus.err_pulse) begin
            pulses++;
            if (!v) pulse_on_invalid++;
        end
        if (bus.locked) locked_seen++;
        if (model_on) begin
            check("rnd_locked", longint'(bus.locked), longint'(m_mode == M_LOCK));
            check("rnd_err_pulse", longint'(bus.err_pulse), longint'(m_pulse));
            check("rnd_err_cnt", longint'(bus.err_cnt), longint'(m_err));
            check("rnd_bit_cnt", longint'(bus.bit_cnt), m_bits);
        end
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
    endtask

    task automatic send(input int n, input int ninv);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = gen_next();
            cycle(b ^ (i < ninv), 1'b1, 1'b0);
        end
    endtask

    task automatic send_gapped(input int n, input int ninv);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = gen_next();
            cycle(b ^ (i < ninv), 1'b1, 1'b0);
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        gen = 31'd1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_locked"},    longint'(bus.locked),    0);
        check({tag, "_err_pulse"}, longint'(bus.err_pulse), 0);
        check({tag, "_err_cnt"},   longint'(bus.err_cnt),   0);
        check({tag, "_bit_cnt"},   longint'(bus.bit_cnt),   0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v;
        bit c;
        bit d;
        bit b;
        int burst;

        model_on         = 0;
        pulses           = 0;
        pulse_on_invalid = 0;
        locked_seen      = 0;

        // Phases applied back to back from reset with generator seed 31'd1.
        vecs[0] = '{"pre_lock",    94,   0,  1'b0, 0, 0,    0};
        vecs[1] = '{"lock_edge",   1,    0,  1'b1, 0, 0,    0};
        vecs[2] = '{"clean_1000",  1000, 0,  1'b1, 0, 1000, 0};
        vecs[3] = '{"single_err",  1,    1,  1'b1, 1, 1001, 1};
        vecs[4] = '{"no_followon", 300,  0,  1'b1, 1, 1301, 0};
        vecs[5] = '{"burst_loss",  16,   16, 1'b0, 9, 1309, 8};
        vecs[6] = '{"pre_relock",  94,   0,  1'b0, 9, 1309, 0};
        vecs[7] = '{"relock",      1,    0,  1'b1, 9, 1309, 0};

        do_reset();
        check_outputs_zero("reset");

        for (int i = 0; i < 8; i++) begin
            pulses = 0;
            send(vecs[i].nbits, vecs[i].ninv);
            check({vecs[i].name, "_locked"},  longint'(bus.locked),  longint'(vecs[i].exp_locked));
            check({vecs[i].name, "_err_cnt"}, longint'(bus.err_cnt), vecs[i].exp_err);
            check({vecs[i].name, "_bit_cnt"}, longint'(bus.bit_cnt), vecs[i].exp_bits);
            check({vecs[i].name, "_pulses"},  pulses,                vecs[i].exp_pulses);
        end

        // Stuck-at-0 line: seed windows are all zero and must keep restarting.
        do_reset();
        locked_seen = 0;
        for (int i = 0; i < 500; i++) cycle(1'b0, 1'b1, 1'b0);
        check("stuck_never_locked", locked_seen, 0);
        check("stuck_err_cnt", longint'(bus.err_cnt), 0);
        // First nonzero window covers PRBS bits 27..57, then 64 checked bits.
        send(121, 0);
        check("stuck_pre_lock", longint'(bus.locked), 0);
        send(1, 0);
        check("stuck_lock", longint'(bus.locked), 1);

        // Gapped input: every valid bit is followed by an invalid cycle with junk data.
        do_reset();
        pulses           = 0;
        pulse_on_invalid = 0;
        send_gapped(94, 0);
        check("gap_pre_lock", longint'(bus.locked), 0);
        send_gapped(1, 0);
        check("gap_lock", longint'(bus.locked), 1);
        send_gapped(1000, 0);
        check("gap_bit_cnt", longint'(bus.bit_cnt), 1000);
        check("gap_err_cnt", longint'(bus.err_cnt), 0);
        send_gapped(1, 1);
        send_gapped(20, 0);
        check("gap_err_one", longint'(bus.err_cnt), 1);
        check("gap_pulses", pulses, 1);
        check("gap_pulse_invalid", pulse_on_invalid, 0);

        // Saturation: isolated errors never share a loss window.
        for (int i = 0; i < 20; i++) begin
            send(1, 1);
            send(299, 0);
        end
        check("sat_err_cnt", longint'(bus.err_cnt), ERR_MAX);
        check("sat_locked", longint'(bus.locked), 1);

        b = gen_next();
        cycle(~b, 1'b1, 1'b1);
        check("clr_err_edge_err", longint'(bus.err_cnt), 1);
        check("clr_err_edge_bits", longint'(bus.bit_cnt), 1);
        check("clr_err_edge_pulse", longint'(bus.err_pulse), 1);

        // Asynchronous reset between clock edges while err_pulse is high.
        send(10, 0);
        b = gen_next();
        cycle(~b, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        gen = 31'd1;

        // Randomized traffic against the behavioural model.
        model_on = 1;
        burst    = 0;
        for (int i = 0; i < 6000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = v && ($urandom_range(0, 99) == 0);
            if (v) begin
                d = gen_next();
                if (burst == 0 && $urandom_range(0, 799) == 0) burst = $urandom_range(4, 14);
                if (burst > 0) begin
                    d = ~d;
                    burst--;
                end else if ($urandom_range(0, 249) == 0) begin
                    d = ~d;
                end
            end else begin
                d = 1'($urandom_range(0, 1));
            end
            cycle(d, v, c);
        end
        model_on = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 checker (x^31 + x^28 + 1) that receives the bit stream produced by the team's PRBS31 generator, self-synchronises to it, declares lock, and counts bit errors. Sits at the receive end of the loopback link, so the generator and checker together form an on-chip or board-level BER test. The checker needs no seed from the transmitter: it fills its history from the incoming data, then predicts each following bit.

## Interface
- LOCK_THRESH, 64: consecutive matching bits in CHECK needed to assert lock (1..1023)
- LOSS_THRESH, 8: errors within one window that drop lock (1..WIN)
- WIN, 256: loss-detection window length in valid bits (power of 2, 2..65536)
- ERR_W, 16: error counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-high (1 = reset)
- din  in  1  received serial bit
- din_valid  in  1  din is sampled on this edge only when 1
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle strobe per mismatched bit while LOCKED
- err_cnt  out  ERR_W  saturating count of errors seen while LOCKED
- bit_cnt  out  32  saturating count of bits checked while LOCKED

## Operation
- History register h[30:0]: h[0] is the newest bit. Expected bit is e = h[27] ^ h[30]. This matches the generator, which loads lfsr[27]^lfsr[30] into bit 0 and outputs lfsr[30].
- All state advances only on edges where din_valid=1. With din_valid=0, every register holds and err_pulse is 0.
- States: SEED, CHECK, LOCKED. Reset state is SEED.
- SEED: shift din into h and count valid bits 0..30.
  - After the 31st bit, go to CHECK if the new h is nonzero.
  - If h is all zero, stay in SEED, clear the count and restart. This prevents lock-up on a stuck-at-0 line.
- CHECK: compare din with e, then shift din into h (self-sync).
  - On a match, increment the run counter. On a mismatch, clear it.
  - Go to LOCKED on the edge that samples the LOCK_THRESH-th consecutive match.
  - No errors are counted in CHECK.
- LOCKED: compare din with e, then shift e (not din) into h, so line errors do not propagate.
  - bit_cnt increments by 1 on each valid bit and saturates at 2^32-1.
  - On a mismatch: pulse err_pulse, increment err_cnt (saturates at 2^ERR_W-1), and increment the window error count err_win.
  - Window counter wcnt counts valid bits 0..WIN-1. On the last bit of a window, that bit's error (if any) is evaluated first, then err_win clears.
  - When err_win reaches LOSS_THRESH: go to SEED, clear the run counter and the seed count.
- On entry to LOCKED, wcnt and err_win both start at 0.
- clr_cnt=1 clears err_cnt and bit_cnt. If a bit is also counted on the same edge, clear applies first, then the count, so the result is 1. clr_cnt does not affect state, h, or the window counters.
- Reset values: state=SEED, h=0, all counters=0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.

## Timing
- All outputs are registered.
- locked rises after the edge that samples the lock-qualifying bit. It falls after the edge that samples the LOSS_THRESH-th windowed error. That error is still counted in err_cnt and pulses err_pulse.
- err_pulse is high for exactly the one cycle after the erroneous bit's sampling edge.
- Minimum lock latency: 31 + LOCK_THRESH valid bits from reset or from loss of lock.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), and reacquisition starts from SEED after rst_n deasserts.
- Throughput: one bit per clock.

## Test plan
- Clean lock: generator seeded 31'd1 feeds din, din_valid=1, defaults.
  - Expected: locked=1 after the edge sampling bit 95 (first 31 bits are 30 zeros then a 1).
  - After a further 1000 bits: err_cnt=0, bit_cnt=1000.
- Single error: after lock, invert one bit.
  - Expected: exactly one err_pulse cycle, err_cnt=1, locked stays 1, no follow-on errors from the taps.
- Burst loss and relock: after lock, invert 16 consecutive bits.
  - Expected: locked falls on the 8th error and err_cnt=8.
  - Once clean data resumes, locked returns after 95 further bits and err_cnt stays 8.
- Stuck line: din=0 for 500 bits.
  - Expected: state never leaves SEED, locked=0, err_cnt=0.
  - Then switch to valid PRBS: lock within 95 bits of the first nonzero seed window.
- Gapped input: din_valid toggling 1,0,1,0.
  - Expected: lock and counts identical to the clean-lock case when measured in valid bits, and err_pulse never asserts on invalid cycles.
- Saturation, clear and reset: ERR_W=4, inject 20 isolated errors spaced more than 256 bits apart.
  - Expected: err_cnt saturates at 15.
  - clr_cnt on an error edge gives err_cnt=1.
  - rst_n=1 mid-lock zeroes all outputs asynchronously.
